pipe_event_counter: RTL and testbench

- Parametrised pipeline event/performance counter bank for the pipelined CPU.
- Replaces ad-hoc stall/flush counting in the bench with in-design hardware counters.
- Counts elapsed cycles plus NUM_EVT single-bit event strobes (stall, flush, retire, …) from the pipeline.
- Supports atomic snapshot and registered readout via a select index.

---
 rtl/pipe_event_counter.sv | 231 +++++++++++++++++++++++
 tb/tb_pipe_event_counter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_event_counter.sv
// pipe_event_counter
// Cycle counter plus NUM_EVT event counters for the pipelined CPU. It has a
// shadow bank for atomic snapshots and a registered readout by index.
// The optional threshold interrupt is built only when PEVT_THRESH_IRQ_EN is
// defined. With the macro undefined there are no extra ports and no extra logic.
//
// state | meaning
// IDLE  | start_i low; live counters hold their values
// RUN   | live counters advance on every edge while in this state
// HOLD  | freeze_i high; live counters hold their values
//
// Counter index NUM_EVT is the cycle counter. Indices 0..NUM_EVT-1 follow evt_i.

module pipe_event_counter #(
  parameter int NUM_EVT  = 4,
  parameter int CNT_W    = 32,
  parameter int SATURATE = 0,
  parameter int SEL_W    = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               freeze_i,
  input  logic               clr_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               snap_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
`ifdef PEVT_THRESH_IRQ_EN
  input  logic [CNT_W-1:0]   thresh_i,
  input  logic [SEL_W-1:0]   thresh_sel_i,
  output logic               irq_o,
`endif
  output logic [CNT_W-1:0]   rd_data_o,
  output logic               snap_valid_o,
  output logic [NUM_EVT:0]   ovf_o,
  output logic [1:0]         state_o
);

  localparam int NCNT = NUM_EVT + 1;
  localparam logic [CNT_W-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  if (NUM_EVT < 1 || NUM_EVT > 15 || CNT_W < 4 || CNT_W > 64 ||
      (1 << SEL_W) < NUM_EVT + 1) begin : g_bad_param
    $error("pipe_event_counter: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   count_en;

  logic [CNT_W-1:0] live     [NCNT];
  logic [CNT_W-1:0] live_nxt [NCNT];
  logic [CNT_W-1:0] shadow   [NCNT];
  logic [NCNT-1:0]  inc;
  logic [NCNT-1:0]  ovf;
  logic [NCNT-1:0]  ovf_nxt;
  logic [CNT_W-1:0] rd_mux;
  logic             snap_valid;
  logic [CNT_W-1:0] rd_data;

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------

  // State register. Reset always returns to IDLE, even when start_i is high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state. Dropping start_i wins over everything else.
  always_comb begin
    state_nxt = state;
    if (!start_i) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_RUN;
        ST_RUN:  state_nxt = freeze_i ? ST_HOLD : ST_RUN;
        ST_HOLD: state_nxt = freeze_i ? ST_HOLD : ST_RUN;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM outputs. Counting follows the registered state, so each state change
  // takes effect one cycle after the edge that makes it.
  always_comb begin
    state_o  = state;
    count_en = (state == ST_RUN);
  end

  // ---------------------------------------------------------------------
  // Live counters
  // ---------------------------------------------------------------------

  // Per-counter increment request. The cycle counter is the top bit.
  always_comb begin
    inc = {1'b1, evt_i} & {NCNT{count_en}};
  end

  // Next live value and overflow flag. A clear beats a same-cycle increment.
  always_comb begin
    ovf_nxt = ovf;
    for (int i = 0; i < NCNT; i++) begin
      live_nxt[i] = live[i];
      if (clr_i) begin
        live_nxt[i] = '0;
        ovf_nxt[i]  = 1'b0;
      end else if (inc[i]) begin
        if (SATURATE != 0) begin
          // The flag rises on the increment that lands on all-ones.
          if (live[i] != ALL_ONES) begin
            live_nxt[i] = live[i] + ONE;
          end
          if (live[i] == ALL_ONES - ONE || live[i] == ALL_ONES) begin
            ovf_nxt[i] = 1'b1;
          end
        end else begin
          // The flag rises on the increment that wraps to zero.
          live_nxt[i] = live[i] + ONE;
          if (live[i] == ALL_ONES) begin
            ovf_nxt[i] = 1'b1;
          end
        end
      end
    end
  end

  // Live counter and sticky overflow registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NCNT; i++) begin
        live[i] <= '0;
      end
      ovf <= '0;
    end else begin
      live <= live_nxt;
      ovf  <= ovf_nxt;
    end
  end

  assign ovf_o = ovf;

  // ---------------------------------------------------------------------
  // Shadow bank and readout
  // ---------------------------------------------------------------------

  // The snapshot takes the pre-edge live values. This edge's increment or
  // clear is not included. A clear does not touch the shadow bank.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NCNT; i++) begin
        shadow[i] <= '0;
      end
      snap_valid <= 1'b0;
    end else if (snap_i) begin
      shadow     <= live;
      snap_valid <= 1'b1;
    end
  end

  assign snap_valid_o = snap_valid;

  // Read mux. An index above NUM_EVT has no match and reads as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NCNT; i++) begin
      if (rd_sel_i == SEL_W'(i)) begin
        rd_mux = shadow[i];
      end
    end
  end

  // Registered readout. A snapshot taken on the same edge is seen on the next read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_mux;
    end
  end

  assign rd_data_o = rd_data;

`ifdef PEVT_THRESH_IRQ_EN
  // ---------------------------------------------------------------------
  // Threshold interrupt
  // ---------------------------------------------------------------------

  logic [CNT_W-1:0] th_nxt;
  logic             th_inc;
  logic             irq;

  // Value and increment request of the watched counter for this edge.
  always_comb begin
    th_nxt = '0;
    th_inc = 1'b0;
    for (int i = 0; i < NCNT; i++) begin
      if (thresh_sel_i == SEL_W'(i)) begin
        th_nxt = live_nxt[i];
        th_inc = inc[i] & ~clr_i;
      end
    end
  end

  // Sticky interrupt. It rises on the same edge the counter reaches the threshold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq <= 1'b0;
    end else if (clr_i) begin
      irq <= 1'b0;
    end else if (th_inc && th_nxt == thresh_i) begin
      irq <= 1'b1;
    end
  end

  assign irq_o = irq;
`endif

endmodule

// File: tb/tb_pipe_event_counter.sv
// Self-checking bench for pipe_event_counter. Two instances share all inputs:
// one wraps (SATURATE=0) and one saturates (SATURATE=1), both with NUM_EVT=2
// and CNT_W=8. Checks come from a vector table, hand sequences, and random
// stimulus against a running-total reference model.

module tb_pipe_event_counter;

  localparam int NE = 2;
  localparam int CW = 8;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          freeze;
  logic          clr;
  logic          snap;
  logic [NE-1:0] evt;
  logic [SW-1:0] sel;

  logic [CW-1:0] rd_w, rd_s;
  logic          valid_w, valid_s;
  logic [NE:0]   ovf_w, ovf_s;
  logic [1:0]    st_w, st_s;
`ifdef PEVT_THRESH_IRQ_EN
  logic          irq_w, irq_s;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_event_counter #(.NUM_EVT(NE), .CNT_W(CW), .SATURATE(0), .SEL_W(SW)) dut_w (
    .clk_i(clk), .rst_i(rst), .start_i(start), .freeze_i(freeze), .clr_i(clr),
    .evt_i(evt), .snap_i(snap), .rd_sel_i(sel),
`ifdef PEVT_THRESH_IRQ_EN
    .thresh_i(8'hff), .thresh_sel_i(2'd3), .irq_o(irq_w),
`endif
    .rd_data_o(rd_w), .snap_valid_o(valid_w), .ovf_o(ovf_w), .state_o(st_w));

  pipe_event_counter #(.NUM_EVT(NE), .CNT_W(CW), .SATURATE(1), .SEL_W(SW)) dut_s (
    .clk_i(clk), .rst_i(rst), .start_i(start), .freeze_i(freeze), .clr_i(clr),
    .evt_i(evt), .snap_i(snap), .rd_sel_i(sel),
`ifdef PEVT_THRESH_IRQ_EN
    .thresh_i(8'hff), .thresh_sel_i(2'd3), .irq_o(irq_s),
`endif
    .rd_data_o(rd_s), .snap_valid_o(valid_s), .ovf_o(ovf_s), .state_o(st_s));

  // Reference model. Each counter is kept as an unbounded running total of
  // increments since the last clear or reset. The visible value and the
  // overflow flag are derived from that total with plain arithmetic.
  int m_tot  [0:NE];
  int m_sh_w [0:NE];
  int m_sh_s [0:NE];
  int m_state;          // 0 idle, 1 run, 2 hold (state_o encoding)
  int m_valid;
  int m_rd_w;
  int m_rd_s;

  function automatic int lv_w(int i);
    return m_tot[i] % 256;
  endfunction

  function automatic int lv_s(int i);
    return (m_tot[i] > 255) ? 255 : m_tot[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= NE; i++) begin
      m_tot[i] = 0; m_sh_w[i] = 0; m_sh_s[i] = 0;
    end
    m_state = 0; m_valid = 0; m_rd_w = 0; m_rd_s = 0;
  endtask

  task automatic model_edge();
    int nrd_w;
    int nrd_s;
    if (rst) begin
      model_reset();
    end else begin
      nrd_w = (int'(sel) <= NE) ? m_sh_w[sel] : 0;
      nrd_s = (int'(sel) <= NE) ? m_sh_s[sel] : 0;
      if (snap) begin
        for (int i = 0; i <= NE; i++) begin
          m_sh_w[i] = lv_w(i);
          m_sh_s[i] = lv_s(i);
        end
        m_valid = 1;
      end
      m_rd_w = nrd_w;
      m_rd_s = nrd_s;
      if (clr) begin
        for (int i = 0; i <= NE; i++) m_tot[i] = 0;
      end else if (m_state == 1) begin
        m_tot[NE]++;
        for (int k = 0; k < NE; k++) if (evt[k]) m_tot[k]++;
      end
      if (!start)            m_state = 0;
      else if (m_state == 0) m_state = 1;
      else if (freeze)       m_state = 2;
      else                   m_state = 1;
    end
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic compare_model(string tag);
    logic [NE:0] eo_w;
    logic [NE:0] eo_s;
    for (int i = 0; i <= NE; i++) begin
      eo_w[i] = (m_tot[i] >= 256);
      eo_s[i] = (m_tot[i] >= 255);
    end
    chk({tag, ".state_w"}, 64'(st_w), 64'(m_state));
    chk({tag, ".state_s"}, 64'(st_s), 64'(m_state));
    chk({tag, ".valid_w"}, 64'(valid_w), 64'(m_valid));
    chk({tag, ".valid_s"}, 64'(valid_s), 64'(m_valid));
    chk({tag, ".ovf_w"}, 64'(ovf_w), 64'(eo_w));
    chk({tag, ".ovf_s"}, 64'(ovf_s), 64'(eo_s));
    chk({tag, ".rd_w"}, 64'(rd_w), 64'(m_rd_w));
    chk({tag, ".rd_s"}, 64'(rd_s), 64'(m_rd_s));
  endtask

  task automatic drive(bit r, bit s, bit f, bit c, bit sn, bit [1:0] e, bit [1:0] sl);
    rst = r; start = s; freeze = f; clr = c; snap = sn; evt = e; sel = sl;
  endtask

  // One cycle: apply the inputs, clock, then compare against the model.
  task automatic cyc(string tag, bit r, bit s, bit f, bit c, bit sn, bit [1:0] e, bit [1:0] sl);
    drive(r, s, f, c, sn, e, sl);
    tick();
    compare_model(tag);
  endtask

  typedef struct {
    bit       r, s, f, c, sn;
    bit [1:0] e;
    bit [1:0] sl;
    bit [1:0] exp_st;
    bit [7:0] exp_rd;
    bit       exp_valid;
    bit [2:0] exp_ovf;
  } vec_t;

  function automatic vec_t mk(bit r, bit s, bit f, bit c, bit sn, bit [1:0] e,
                              bit [1:0] sl, bit [1:0] es, bit [7:0] erd, bit ev,
                              bit [2:0] eo);
    vec_t v;
    v.r = r; v.s = s; v.f = f; v.c = c; v.sn = sn; v.e = e; v.sl = sl;
    v.exp_st = es; v.exp_rd = erd; v.exp_valid = ev; v.exp_ovf = eo;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    bit [1:0] cnt_pat [10];
    cnt_pat = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};

    model_reset();
    drive(1, 0, 0, 0, 0, 2'b00, 2'b00);

    // Reset and idle, then basic count, snapshot and readout.
    for (int i = 0; i < 2; i++) tbl.push_back(mk(1,0,0,0,0,2'b11,2'd0, 2'd0,8'd0,0,3'd0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,0,0,0,2'b11,2'd2, 2'd0,8'd0,0,3'd0));
    tbl.push_back(mk(0,1,0,0,0,2'b00,2'd0, 2'd1,8'd0,0,3'd0));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(0,1,0,0,0,cnt_pat[i],2'd0, 2'd1,8'd0,0,3'd0));
    tbl.push_back(mk(0,0,0,0,1,2'b00,2'd0, 2'd0,8'd0,1,3'd0));
    tbl.push_back(mk(0,0,0,0,0,2'b00,2'd0, 2'd0,8'd4,1,3'd0));
    tbl.push_back(mk(0,0,0,0,0,2'b00,2'd1, 2'd0,8'd7,1,3'd0));
    tbl.push_back(mk(0,0,0,0,0,2'b00,2'd2, 2'd0,8'd10,1,3'd0));
    tbl.push_back(mk(0,0,0,0,0,2'b00,2'd3, 2'd0,8'd0,1,3'd0));

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].c, tbl[i].sn, tbl[i].e, tbl[i].sl);
      tick();
      chk($sformatf("tbl%0d.state_w", i), 64'(st_w), 64'(tbl[i].exp_st));
      chk($sformatf("tbl%0d.state_s", i), 64'(st_s), 64'(tbl[i].exp_st));
      chk($sformatf("tbl%0d.rd_w", i), 64'(rd_w), 64'(tbl[i].exp_rd));
      chk($sformatf("tbl%0d.rd_s", i), 64'(rd_s), 64'(tbl[i].exp_rd));
      chk($sformatf("tbl%0d.valid_w", i), 64'(valid_w), 64'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d.ovf_w", i), 64'(ovf_w), 64'(tbl[i].exp_ovf));
      compare_model($sformatf("tbl%0d.model", i));
    end

    // Freeze: 3 run cycles, then 5 frozen cycles (the first of them still
    // counts), then 2 run cycles (the first leaves HOLD) -> 5 counts.
    cyc("frz.clr", 0,0,0,1,0,2'b00,2'd0);
    cyc("frz.go", 0,1,0,0,0,2'b00,2'd0);
    for (int i = 0; i < 3; i++) cyc("frz.run", 0,1,0,0,0,2'b11,2'd0);
    for (int i = 0; i < 5; i++) begin
      cyc("frz.hold", 0,1,1,0,0,2'b11,2'd0);
      chk("frz.state_hold", 64'(st_w), 64'd2);
    end
    for (int i = 0; i < 2; i++) cyc("frz.resume", 0,1,0,0,0,2'b11,2'd0);
    cyc("frz.snap", 0,0,0,0,1,2'b00,2'd0);
    for (int i = 0; i < 3; i++) begin
      cyc("frz.read", 0,0,0,0,0,2'b00,2'(i));
      chk($sformatf("frz.rd%0d", i), 64'(rd_w), 64'd5);
    end

    // Wrap versus saturate after 257 counted cycles.
    cyc("wrp.clr", 0,0,0,1,0,2'b00,2'd0);
    cyc("wrp.go", 0,1,0,0,0,2'b00,2'd0);
    for (int i = 0; i < 257; i++) cyc("wrp.run", 0,1,0,0,0,2'b00,2'd0);
    cyc("wrp.snap", 0,0,0,0,1,2'b00,2'd2);
    chk("wrp.ovf_w", 64'(ovf_w), 64'd4);
    chk("wrp.ovf_s", 64'(ovf_s), 64'd4);
    cyc("wrp.read", 0,0,0,0,0,2'b00,2'd2);
    chk("wrp.rd_w", 64'(rd_w), 64'd1);
    chk("wrp.rd_s", 64'(rd_s), 64'd255);
    cyc("wrp.clr2", 0,0,0,1,0,2'b00,2'd2);
    chk("wrp.ovf_w_clr", 64'(ovf_w), 64'd0);
    chk("wrp.ovf_s_clr", 64'(ovf_s), 64'd0);

    // Clear and snapshot on the same edge after 20 counted cycles.
    cyc("col.go", 0,1,0,0,0,2'b00,2'd2);
    for (int i = 0; i < 20; i++) cyc("col.run", 0,1,0,0,0,2'b01,2'd2);
    cyc("col.clrsnap", 0,1,0,1,1,2'b00,2'd2);
    chk("col.ovf", 64'(ovf_w), 64'd0);
    cyc("col.c1", 0,1,0,0,0,2'b00,2'd2);
    chk("col.shadow20_w", 64'(rd_w), 64'd20);
    chk("col.shadow20_s", 64'(rd_s), 64'd20);
    cyc("col.c2", 0,0,0,0,1,2'b00,2'd2);
    chk("col.oldread", 64'(rd_w), 64'd20);
    cyc("col.c3", 0,0,0,0,0,2'b00,2'd2);
    chk("col.live1", 64'(rd_w), 64'd1);

    // Reset in the middle of a run with start_i held high.
    cyc("rmr.clr", 0,0,0,1,0,2'b00,2'd2);
    cyc("rmr.go", 0,1,0,0,0,2'b00,2'd2);
    for (int i = 0; i < 6; i++) cyc("rmr.run", 0,1,0,0,0,2'b11,2'd2);
    cyc("rmr.rst", 1,1,0,0,0,2'b11,2'd2);
    chk("rmr.state_idle", 64'(st_w), 64'd0);
    chk("rmr.valid0", 64'(valid_w), 64'd0);
    chk("rmr.rd0", 64'(rd_w), 64'd0);
    cyc("rmr.e1", 0,1,0,0,0,2'b11,2'd2);
    chk("rmr.state_run", 64'(st_w), 64'd1);
    cyc("rmr.e2", 0,1,0,0,0,2'b11,2'd2);
    cyc("rmr.e3", 0,1,0,0,1,2'b11,2'd2);
    cyc("rmr.e4", 0,0,0,0,0,2'b00,2'd2);
    chk("rmr.cyc1", 64'(rd_w), 64'd1);
    cyc("rmr.e5", 0,0,0,0,0,2'b00,2'd0);
    chk("rmr.evt1", 64'(rd_w), 64'd1);

    // Random traffic against the model.
    drive(0, 1, 0, 0, 0, 2'b00, 2'd0);
    for (int n = 0; n < 4000; n++) begin
      rst   = ($urandom_range(0, 1499) == 0);
      start = ($urandom_range(0, 39) != 0);
      if (freeze) freeze = ($urandom_range(0, 3) != 0);
      else        freeze = ($urandom_range(0, 15) == 0);
      clr   = ($urandom_range(0, 999) == 0);
      snap  = ($urandom_range(0, 5) == 0);
      evt   = 2'($urandom_range(0, 3));
      sel   = 2'($urandom_range(0, 3));
      tick();
      compare_model("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
